// File: rtl/rqfe_pkg.sv
// Shared types and default sizing for the arbiter request front end.
package rqfe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int MAX_PENDING_D = 7;
    localparam int CNT_W_D       = 3;
    localparam int BURST_LEN_D   = 4;
    localparam int BL_W_D        = 2;

endpackage

// File: rtl/client_req_ctrl.sv
// One client's request controller: pending counter, burst tenure FSM,
// beat counter and sticky overflow.
module client_req_ctrl
    import rqfe_pkg::*;
#(
    parameter int MAX_PENDING = MAX_PENDING_D,
    parameter int CNT_W       = CNT_W_D,
    parameter int BURST_LEN   = BURST_LEN_D,
    parameter int BL_W        = BL_W_D
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_gnt,
    output logic             o_req,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pend,
    output logic             o_ovf
);

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_pend_nxt;
    logic [BL_W-1:0]  r_beats;
    logic [BL_W-1:0]  w_beats_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_dec;
    logic             r_req;
    logic             r_busy;
    logic             r_done;

    always_comb begin
        w_nxt       = r_state;
        w_beats_nxt = r_beats;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != '0) w_nxt = WAIT;
            end
            WAIT: begin
                if (i_gnt) begin
                    w_nxt       = BUSY;
                    w_beats_nxt = '0;
                end
            end
            BUSY: begin
                // Beats only advance on granted cycles; G=0 stalls.
                if (i_gnt) begin
                    if (r_beats == BL_W'(BURST_LEN - 1)) begin
                        w_nxt = RELEASE;
                        w_dec = 1'b1;
                    end else begin
                        w_beats_nxt = r_beats + 1'b1;
                    end
                end
            end
            RELEASE: begin
                w_nxt = (r_pend != '0) ? WAIT : IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (i_req && !w_dec) begin
            if (r_pend == CNT_W'(MAX_PENDING)) w_ovf_nxt = 1'b1;
            else w_pend_nxt = r_pend + 1'b1;
        end else if (!i_req && w_dec) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    // Outputs are registered from the next state so R never sees G
    // combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pend  <= w_pend_nxt;
            r_beats <= w_beats_nxt;
            r_ovf   <= w_ovf_nxt;
            r_req   <= (w_nxt == WAIT) || (w_nxt == BUSY);
            r_busy  <= (w_nxt == BUSY);
            r_done  <= (w_nxt == RELEASE);
        end
    end

    assign o_req  = r_req;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/request_front_end.sv
// Two independent client request controllers feeding the 2-client arbiter.
module request_front_end
    import rqfe_pkg::*;
#(
    parameter int MAX_PENDING = MAX_PENDING_D,
    parameter int CNT_W       = CNT_W_D,
    parameter int BURST_LEN   = BURST_LEN_D,
    parameter int BL_W        = BL_W_D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in0,
    input  logic             req_in1,
    input  logic             G0,
    input  logic             G1,
    output logic             R0,
    output logic             R1,
    output logic             busy0,
    output logic             busy1,
    output logic             done0,
    output logic             done1,
    output logic [CNT_W-1:0] pending0,
    output logic [CNT_W-1:0] pending1,
    output logic             overflow0,
    output logic             overflow1
);

    client_req_ctrl #(
        .MAX_PENDING(MAX_PENDING),
        .CNT_W      (CNT_W),
        .BURST_LEN  (BURST_LEN),
        .BL_W       (BL_W)
    ) u_c0 (
        .i_clk (clock),
        .i_rst (reset),
        .i_req (req_in0),
        .i_gnt (G0),
        .o_req (R0),
        .o_busy(busy0),
        .o_done(done0),
        .o_pend(pending0),
        .o_ovf (overflow0)
    );

    client_req_ctrl #(
        .MAX_PENDING(MAX_PENDING),
        .CNT_W      (CNT_W),
        .BURST_LEN  (BURST_LEN),
        .BL_W       (BL_W)
    ) u_c1 (
        .i_clk (clock),
        .i_rst (reset),
        .i_req (req_in1),
        .i_gnt (G1),
        .o_req (R1),
        .o_busy(busy1),
        .o_done(done1),
        .o_pend(pending1),
        .o_ovf (overflow1)
    );

endmodule

// File: tb/tb_request_front_end.sv
// Directed bench for request_front_end; done pulses are matched against
// a queue of expected completion cycles.
module tb_request_front_end;

    logic       clock;
    logic       reset;
    logic       req_in0;
    logic       req_in1;
    logic       G0;
    logic       G1;
    logic       R0;
    logic       R1;
    logic       busy0;
    logic       busy1;
    logic       done0;
    logic       done1;
    logic [2:0] pending0;
    logic [2:0] pending1;
    logic       overflow0;
    logic       overflow1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q0[$];
    int q1[$];

    request_front_end dut (
        .clock    (clock),
        .reset    (reset),
        .req_in0  (req_in0),
        .req_in1  (req_in1),
        .G0       (G0),
        .G1       (G1),
        .R0       (R0),
        .R1       (R1),
        .busy0    (busy0),
        .busy1    (busy1),
        .done0    (done0),
        .done1    (done1),
        .pending0 (pending0),
        .pending1 (pending1),
        .overflow0(overflow0),
        .overflow1(overflow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, score any done pulses.
    task automatic tick();
        int e;
        @(posedge clock);
        #1;
        cyc++;
        if (done0 === 1'b1) begin
            chk("done0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("done0_cycle", 32'(cyc), 32'(e));
            end
        end
        if (done1 === 1'b1) begin
            chk("done1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("done1_cycle", 32'(cyc), 32'(e));
            end
        end
    endtask

    initial begin
        int k;
        int n;
        reset   = 1'b1;
        req_in0 = 1'b0;
        req_in1 = 1'b0;
        G0      = 1'b0;
        G1      = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_R0", 32'(R0), 32'd0);
        chk("rst_R1", 32'(R1), 32'd0);
        chk("rst_pend0", 32'(pending0), 32'd0);
        chk("rst_pend1", 32'(pending1), 32'd0);
        chk("rst_ovf0", 32'(overflow0), 32'd0);
        chk("rst_ovf1", 32'(overflow1), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        reset = 1'b0;

        // Single transaction with grant held high
        G0      = 1'b1;
        req_in0 = 1'b1;
        k = cyc + 1;
        q0.push_back(k + 6);
        tick();
        req_in0 = 1'b0;
        chk("single_pend1", 32'(pending0), 32'd1);
        chk("single_R0_lat", 32'(R0), 32'd0);
        n = 0;
        for (int i = 0; i < 20 && done0 !== 1'b1; i++) begin
            tick();
            if (R0 === 1'b1) n++;
        end
        chk("single_R0_cycles", 32'(n), 32'd5);
        chk("single_done", 32'(done0), 32'd1);
        chk("single_R0_rel", 32'(R0), 32'd0);
        chk("single_pend0", 32'(pending0), 32'd0);
        tick();
        chk("single_idle_R0", 32'(R0), 32'd0);
        chk("single_idle_busy", 32'(busy0), 32'd0);

        // Saturation on client 1
        req_in1 = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        req_in1 = 1'b0;
        chk("sat_pend1", 32'(pending1), 32'd7);
        chk("sat_ovf1", 32'(overflow1), 32'd1);
        chk("sat_R1", 32'(R1), 32'd1);
        G1 = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 7; i++) q1.push_back(k + 4 + 6 * i);
        for (int i = 0; i < 45; i++) tick();
        chk("sat_drain_pend1", 32'(pending1), 32'd0);
        chk("sat_drain_ovf1", 32'(overflow1), 32'd1);
        chk("sat_drain_q1", 32'(q1.size()), 32'd0);
        G1 = 1'b0;

        // Simultaneous increment and decrement
        G0      = 1'b0;
        req_in0 = 1'b1;
        tick();
        tick();
        req_in0 = 1'b0;
        chk("simul_pend_pre", 32'(pending0), 32'd2);
        G0 = 1'b1;
        k = cyc + 1;
        q0.push_back(k + 4);
        q0.push_back(k + 10);
        q0.push_back(k + 16);
        for (int i = 0; i < 4; i++) tick();
        req_in0 = 1'b1;
        tick();
        req_in0 = 1'b0;
        chk("simul_pend", 32'(pending0), 32'd2);
        chk("simul_done", 32'(done0), 32'd1);
        tick();
        chk("simul_wait_R0", 32'(R0), 32'd1);
        chk("simul_wait_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("simul_drain", 32'(pending0), 32'd0);

        // Grant stall for three cycles mid-burst
        req_in0 = 1'b1;
        k = cyc + 1;
        q0.push_back(k + 9);
        tick();
        req_in0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        G0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy0", 32'(busy0), 32'd1);
            chk("stall_R0", 32'(R0), 32'd1);
        end
        G0 = 1'b1;
        tick();
        chk("stall_not_done", 32'(done0), 32'd0);
        tick();
        chk("stall_done", 32'(done0), 32'd1);
        tick();

        // Reset mid-burst
        G0      = 1'b0;
        req_in0 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        req_in0 = 1'b0;
        G0 = 1'b1;
        tick();
        tick();
        chk("mid_busy0", 32'(busy0), 32'd1);
        chk("mid_pend0", 32'(pending0), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pend0", 32'(pending0), 32'd0);
        chk("mid_rst_R0", 32'(R0), 32'd0);
        chk("mid_rst_busy0", 32'(busy0), 32'd0);
        chk("mid_rst_done0", 32'(done0), 32'd0);
        chk("mid_rst_ovf1", 32'(overflow1), 32'd0);
        G0 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_idle_R0", 32'(R0), 32'd0);

        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
